// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: host command/config decode and job FSM for the conv pipeline.
// Define JOB_WATCHDOG_EN to add a stall watchdog in the RUN state.
module conv_job_sequencer #(
    parameter int CNT_W          = 24,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_wren,
    input  logic        cmd_open,
    input  logic [4:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        cfg_wren,
    input  logic        kern_wren,
    input  logic        feat_wren,
    input  logic        res_push,
    input  logic        pipe_done,
    output logic        kern_full,
    output logic        feat_full,
    output logic        pipe_start,
    output logic        pipe_flush,
    output logic        rd_eof,
    output logic        irq,
    output logic [3:0]  status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADK,
        S_START,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] CMD_LOAD_K  = 8'h01;
    localparam logic [7:0] CMD_RUN     = 8'h02;
    localparam logic [7:0] CMD_ABORT   = 8'h03;
    localparam logic [7:0] CMD_CLR_ERR = 8'h04;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state, state_n;

    logic [CNT_W-1:0] k_words, f_words, r_words;
    logic [CNT_W-1:0] kern_cnt, feat_cnt, res_cnt;
    logic [7:0]       cmd_q;
    logic             cmd_v_q, open_q, done_seen;
    logic             kern_loaded, done_q, rd_eof_q, flush_q, irq_q;

    logic is_load, is_run, is_abort, is_clr, is_bad;
    logic open_fall, abort_req, run_ok;
    logic kern_gate, feat_gate, res_ovf, err_ev, job_complete, wd_ev;
    logic kl_set, kl_clr, abort_go, enter_err, enter_done;
    logic unused_cfg;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign unused_cfg = ^cfg_data;

    always_comb begin
        is_load  = cmd_v_q && (cmd_q == CMD_LOAD_K);
        is_run   = cmd_v_q && (cmd_q == CMD_RUN);
        is_abort = cmd_v_q && (cmd_q == CMD_ABORT);
        is_clr   = cmd_v_q && (cmd_q == CMD_CLR_ERR);
        is_bad   = cmd_v_q && !(is_load || is_run || is_abort || is_clr);
    end

    assign open_fall = open_q && !cmd_open;
    assign abort_req = is_abort || open_fall;
    assign run_ok    = kern_loaded && (f_words != '0) && (r_words != '0);

    // A gate closes as soon as its count reaches the programmed size.
    assign kern_gate = (state == S_LOADK) && (kern_cnt != k_words);
    assign feat_gate = (state == S_RUN) && (feat_cnt != f_words);
    assign res_ovf   = res_push && !((state == S_RUN) && (res_cnt != r_words));

    assign err_ev = is_bad
                  || (cfg_wren && (state != S_IDLE))
                  || (kern_wren && !kern_gate)
                  || (feat_wren && !feat_gate)
                  || res_ovf;

    assign job_complete = (state == S_RUN)
                        && (feat_cnt == f_words)
                        && (res_cnt == r_words)
                        && (pipe_done || done_seen);

`ifdef JOB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            wd_cnt <= '0;
        end else if (state != S_RUN || feat_wren || res_push) begin
            wd_cnt <= '0;
        end else if (!wd_ev) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_ev = (state == S_RUN) && (wd_cnt == WD_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign wd_ev = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        kl_set   = 1'b0;
        kl_clr   = 1'b0;
        abort_go = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (err_ev || (is_run && !run_ok)) begin
                    state_n = S_ERR;
                end else if (is_load && (k_words != '0)) begin
                    state_n = S_LOADK;
                    kl_clr  = 1'b1;
                end else if (is_run) begin
                    state_n = S_START;
                end
            end
            S_LOADK: begin
                if (abort_req) begin
                    state_n  = S_IDLE;
                    abort_go = 1'b1;
                    kl_clr   = 1'b1;
                end else if (err_ev) begin
                    state_n = S_ERR;
                end else if (kern_cnt == k_words) begin
                    state_n = S_IDLE;
                    kl_set  = 1'b1;
                end
            end
            S_START: begin
                if (abort_req) begin
                    state_n  = S_IDLE;
                    abort_go = 1'b1;
                end else if (err_ev) begin
                    state_n = S_ERR;
                end else begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_req) begin
                    state_n  = S_IDLE;
                    abort_go = 1'b1;
                end else if (err_ev) begin
                    state_n = S_ERR;
                end else if (job_complete) begin
                    state_n = S_DONE;
                end else if (wd_ev) begin
                    state_n = S_ERR;
                end
            end
            S_DONE: begin
                state_n = err_ev ? S_ERR : S_IDLE;
            end
            S_ERR: begin
                if (!err_ev && is_clr) begin
                    state_n = S_IDLE;
                    kl_clr  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign enter_err  = (state_n == S_ERR) && (state != S_ERR);
    assign enter_done = (state_n == S_DONE);

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state   <= S_IDLE;
            cmd_q   <= '0;
            cmd_v_q <= 1'b0;
            open_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cmd_q   <= cmd_data;
            cmd_v_q <= cmd_wren;
            open_q  <= cmd_open;
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            k_words <= '0;
            f_words <= '0;
            r_words <= '0;
        end else if (cfg_wren && (state == S_IDLE)) begin
            case (cfg_addr)
                5'd0:    k_words <= cfg_data[CNT_W-1:0];
                5'd1:    f_words <= cfg_data[CNT_W-1:0];
                5'd2:    r_words <= cfg_data[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Counters live only in their own state, so leaving it clears them.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            kern_cnt  <= '0;
            feat_cnt  <= '0;
            res_cnt   <= '0;
            done_seen <= 1'b0;
        end else begin
            if (state != S_LOADK)
                kern_cnt <= '0;
            else if (kern_wren && kern_gate)
                kern_cnt <= sat_inc(kern_cnt);

            if (state != S_RUN)
                feat_cnt <= '0;
            else if (feat_wren && feat_gate)
                feat_cnt <= sat_inc(feat_cnt);

            if (state != S_RUN)
                res_cnt <= '0;
            else if (res_push && (res_cnt != r_words))
                res_cnt <= sat_inc(res_cnt);

            done_seen <= (state == S_RUN) && (done_seen || pipe_done);
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            kern_loaded <= 1'b0;
            done_q      <= 1'b0;
            rd_eof_q    <= 1'b0;
            flush_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            flush_q <= enter_err || abort_go;
            irq_q   <= enter_err || enter_done;
            if (kl_set)
                kern_loaded <= 1'b1;
            else if (kl_clr)
                kern_loaded <= 1'b0;
            if (enter_done) begin
                rd_eof_q <= 1'b1;
                done_q   <= 1'b1;
            end else if (state_n == S_START) begin
                rd_eof_q <= 1'b0;
                done_q   <= 1'b0;
            end
        end
    end

    assign kern_full  = !kern_gate;
    assign feat_full  = !feat_gate;
    assign pipe_start = (state == S_START);
    assign pipe_flush = flush_q;
    assign rd_eof     = rd_eof_q;
    assign irq        = irq_q;
    assign status     = {state == S_ERR,
                         done_q,
                         (state != S_IDLE) && (state != S_ERR),
                         kern_loaded};

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Bench for conv_job_sequencer: command table, job sequences, irq scoreboard.
// Each irq pops an expected {err, rd_eof} record pushed when stimulus was driven.
`timescale 1ns/1ps
module tb_conv_job_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cmd_data = '0;
    logic        cmd_wren = 1'b0;
    logic        cmd_open = 1'b1;
    logic [4:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        cfg_wren = 1'b0;
    logic        kern_wren = 1'b0;
    logic        feat_wren = 1'b0;
    logic        res_push = 1'b0;
    logic        pipe_done = 1'b0;
    logic        kern_full, feat_full, pipe_start, pipe_flush, rd_eof, irq;
    logic [3:0]  status;

    conv_job_sequencer #(
        .CNT_W(24),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .bus_clk(clk),
        .bus_rst_n(rst_n),
        .cmd_data(cmd_data),
        .cmd_wren(cmd_wren),
        .cmd_open(cmd_open),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .cfg_wren(cfg_wren),
        .kern_wren(kern_wren),
        .feat_wren(feat_wren),
        .res_push(res_push),
        .pipe_done(pipe_done),
        .kern_full(kern_full),
        .feat_full(feat_full),
        .pipe_start(pipe_start),
        .pipe_flush(pipe_flush),
        .rd_eof(rd_eof),
        .irq(irq),
        .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic exp_err;
        logic exp_eof;
    } irq_exp_t;

    typedef struct {
        logic [7:0] cmd;
        logic [3:0] exp_status;
        logic       exp_kfull;
        int         exp_flush;
    } vec_t;

    irq_exp_t sb_q[$];
    vec_t     vecs[7];
    int n_checks = 0;
    int n_errors = 0;
    int n_start = 0;
    int n_flush = 0;
    int n_irq = 0;
    int s0, f0, i0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        irq_exp_t e;
        @(posedge clk);
        #1;
        n_start += int'(pipe_start);
        n_flush += int'(pipe_flush);
        n_irq   += int'(irq);
        if (irq) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_irq: got irq=1 expected none");
            end else begin
                e = sb_q.pop_front();
                check("irq_err", 32'(status[3]), 32'(e.exp_err));
                check("irq_eof", 32'(rd_eof), 32'(e.exp_eof));
            end
        end
    endtask

    task automatic do_reset();
        cmd_wren = 0; cfg_wren = 0; kern_wren = 0;
        feat_wren = 0; res_push = 0; pipe_done = 0; cmd_open = 1;
        rst_n = 0;
        #2;
        check("reset_outs", 32'({kern_full, feat_full, pipe_start, pipe_flush,
                                 rd_eof, irq, status}), 32'h300);
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
        cfg_addr = a; cfg_data = d; cfg_wren = 1;
        tick();
        cfg_wren = 0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        cmd_data = b; cmd_wren = 1;
        tick();
        cmd_wren = 0;
        tick();
    endtask

    task automatic words(input logic k, input logic f, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            kern_wren = k; feat_wren = f; res_push = r;
            tick();
        end
        kern_wren = 0; feat_wren = 0; res_push = 0;
    endtask

    task automatic setup_job(input int k, input int f, input int r);
        cfg_write(5'd0, 32'(k));
        cfg_write(5'd1, 32'(f));
        cfg_write(5'd2, 32'(r));
        send_cmd(8'h01);
        words(1, 0, 0, k);
        tick();
    endtask

    task automatic start_run();
        send_cmd(8'h02);
        tick();
    endtask

    initial begin
        vecs[0] = '{8'h04, 4'b0000, 1'b1, 0};
        vecs[1] = '{8'h03, 4'b0000, 1'b1, 0};
        vecs[2] = '{8'h02, 4'b1000, 1'b1, 1};
        vecs[3] = '{8'h00, 4'b1000, 1'b1, 1};
        vecs[4] = '{8'h05, 4'b1000, 1'b1, 1};
        vecs[5] = '{8'hFF, 4'b1000, 1'b1, 1};
        vecs[6] = '{8'h01, 4'b0010, 1'b0, 1};

        // Command decode table from a freshly reset, configured IDLE
        for (int i = 0; i < 7; i++) begin
            do_reset();
            cfg_write(5'd0, 32'd3);
            cfg_write(5'd1, 32'd4);
            cfg_write(5'd2, 32'd4);
            f0 = n_flush; s0 = n_start;
            if (vecs[i].exp_status[3]) sb_q.push_back('{1'b1, 1'b0});
            send_cmd(vecs[i].cmd);
            check($sformatf("vec%0d_status", i), 32'(status), 32'(vecs[i].exp_status));
            check($sformatf("vec%0d_kfull", i), 32'(kern_full), 32'(vecs[i].exp_kfull));
            if (vecs[i].exp_status[3]) send_cmd(8'h04);
            else if (vecs[i].exp_status[1]) send_cmd(8'h03);
            tick();
            check($sformatf("vec%0d_recover", i), 32'(status), 32'h0);
            check($sformatf("vec%0d_flush", i), 32'(n_flush - f0), 32'(vecs[i].exp_flush));
            check($sformatf("vec%0d_nostart", i), 32'(n_start - s0), 32'h0);
            check($sformatf("vec%0d_sb", i), 32'(sb_q.size()), 32'h0);
        end

        // T1 config, load and run
        do_reset();
        cfg_write(5'd0, 32'd9);
        cfg_write(5'd1, 32'd16);
        cfg_write(5'd2, 32'd16);
        send_cmd(8'h01);
        check("t1_loadk_kfull", 32'(kern_full), 32'h0);
        check("t1_loadk_status", 32'(status), 32'h2);
        words(1, 0, 0, 9);
        check("t1_kfull_closed", 32'(kern_full), 32'h1);
        tick();
        check("t1_kern_loaded", 32'(status), 32'h1);
        s0 = n_start; i0 = n_irq;
        sb_q.push_back('{1'b0, 1'b1});
        send_cmd(8'h02);
        check("t1_start_pulse", 32'(pipe_start), 32'h1);
        tick();
        check("t1_feat_open", 32'(feat_full), 32'h0);
        words(0, 1, 1, 16);
        check("t1_feat_closed", 32'(feat_full), 32'h1);
        check("t1_eof_low", 32'(rd_eof), 32'h0);
        pipe_done = 1;
        tick();
        pipe_done = 0;
        tick();
        tick();
        check("t1_eof", 32'(rd_eof), 32'h1);
        check("t1_status", 32'(status), 32'h5);
        check("t1_irq_count", 32'(n_irq - i0), 32'h1);
        check("t1_start_count", 32'(n_start - s0), 32'h1);
        check("t1_sb", 32'(sb_q.size()), 32'h0);

        // T2 RUN without LOAD_K
        do_reset();
        cfg_write(5'd1, 32'd4);
        cfg_write(5'd2, 32'd4);
        s0 = n_start; f0 = n_flush;
        sb_q.push_back('{1'b1, 1'b0});
        send_cmd(8'h02);
        tick();
        check("t2_no_start", 32'(n_start - s0), 32'h0);
        check("t2_err", 32'(status[3]), 32'h1);
        check("t2_flush", 32'(n_flush - f0), 32'h1);
        send_cmd(8'h03);
        repeat (5) tick();
        check("t2_err_held", 32'(status[3]), 32'h1);
        send_cmd(8'h04);
        check("t2_cleared", 32'(status), 32'h0);

        // T3 ABORT mid-run, then full rerun, then cmd_open drop in LOADK
        do_reset();
        setup_job(2, 16, 16);
        start_run();
        words(0, 1, 0, 5);
        f0 = n_flush;
        send_cmd(8'h03);
        tick();
        check("t3_flush", 32'(n_flush - f0), 32'h1);
        check("t3_ffull", 32'(feat_full), 32'h1);
        check("t3_status", 32'(status), 32'h1);
        sb_q.push_back('{1'b0, 1'b1});
        start_run();
        words(0, 1, 1, 16);
        pipe_done = 1;
        tick();
        pipe_done = 0;
        tick();
        check("t3_rerun_eof", 32'(rd_eof), 32'h1);
        check("t3_rerun_status", 32'(status), 32'h5);
        check("t3_sb", 32'(sb_q.size()), 32'h0);
        send_cmd(8'h01);
        f0 = n_flush;
        cmd_open = 0;
        tick();
        cmd_open = 1;
        tick();
        check("t3_open_status", 32'(status), 32'h4);
        check("t3_open_flush", 32'(n_flush - f0), 32'h1);
        check("t3_open_kfull", 32'(kern_full), 32'h1);

        // T4 feature overflow
        do_reset();
        setup_job(1, 16, 16);
        start_run();
        words(0, 1, 0, 16);
        f0 = n_flush; i0 = n_irq;
        sb_q.push_back('{1'b1, 1'b0});
        words(0, 1, 0, 1);
        tick();
        check("t4_err", 32'(status[3]), 32'h1);
        check("t4_flush", 32'(n_flush - f0), 32'h1);
        check("t4_irq", 32'(n_irq - i0), 32'h1);
        repeat (3) tick();
        check("t4_ffull", 32'(feat_full), 32'h1);
        send_cmd(8'h04);
        check("t4_cleared", 32'(status), 32'h0);

        // T5 early pipe_done: DONE one cycle after the last res_push
        do_reset();
        setup_job(1, 2, 4);
        start_run();
        words(0, 1, 0, 2);
        words(0, 0, 1, 1);
        pipe_done = 1;
        tick();
        pipe_done = 0;
        words(0, 0, 1, 2);
        i0 = n_irq;
        sb_q.push_back('{1'b0, 1'b1});
        res_push = 1;
        tick();
        res_push = 0;
        check("t5_not_yet_eof", 32'(rd_eof), 32'h0);
        check("t5_not_yet_irq", 32'(n_irq - i0), 32'h0);
        check("t5_busy", 32'(status[1]), 32'h1);
        tick();
        check("t5_eof", 32'(rd_eof), 32'h1);
        check("t5_irq", 32'(n_irq - i0), 32'h1);

        // T6 stall in RUN after 4 words
        do_reset();
        setup_job(1, 8, 8);
        start_run();
        words(0, 1, 1, 4);
`ifdef JOB_WATCHDOG_EN
        repeat (99) tick();
        check("t6_wd_before", 32'(status[3]), 32'h0);
        sb_q.push_back('{1'b1, 1'b0});
        tick();
        check("t6_wd_err", 32'(status[3]), 32'h1);
        send_cmd(8'h04);
        check("t6_wd_cleared", 32'(status), 32'h0);
`else
        repeat (1000) tick();
        check("t6_no_err", 32'(status[3]), 32'h0);
        check("t6_still_busy", 32'(status[1]), 32'h1);
        sb_q.push_back('{1'b0, 1'b1});
        words(0, 1, 1, 4);
        pipe_done = 1;
        tick();
        pipe_done = 0;
        tick();
        check("t6_finish_eof", 32'(rd_eof), 32'h1);
`endif
        check("t6_sb", 32'(sb_q.size()), 32'h0);

        // Config write while busy, then reset mid-job without flush
        do_reset();
        cfg_write(5'd0, 32'd3);
        send_cmd(8'h01);
        sb_q.push_back('{1'b1, 1'b0});
        cfg_write(5'd1, 32'd5);
        tick();
        check("t7_cfg_err", 32'(status[3]), 32'h1);
        send_cmd(8'h04);
        check("t7_cleared", 32'(status), 32'h0);
        setup_job(1, 4, 4);
        start_run();
        words(0, 1, 1, 2);
        f0 = n_flush;
        do_reset();
        repeat (3) tick();
        check("t8_no_flush", 32'(n_flush - f0), 32'h0);
        check("t8_status", 32'(status), 32'h0);
        check("t8_sb", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
